vram_text_writer: RTL and testbench

//  Text-console front end for video RAM. Accepts a byte stream of character codes over a valid/ready

---
 rtl/vram_text_writer.sv | 204 ++++++++++++++++++++
 tb/tb_vram_text_writer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_text_writer.sv
// Text-console writer: turns a byte stream into glyph writes on VRAM port B with cursor, wrap, clear and scroll.
// Latency: a printable code is written 1 cycle after its transfer; full clear 2400 cycles, scroll 4640+80 cycles.
// Backpressure: char_ready_o is high only in IDLE; the source must hold char_i/char_valid_i until accepted.
//
// Build option: define VRAM_WRITER_SCROLL_EN to scroll the screen up on a row advance from the last row.
// Without it the cursor wraps to row 0 and only that row is blanked (ring-buffer console).
//
// Ports:
//   clk_i, reset_i           clock, synchronous active-high reset
//   char_i/char_valid_i      character byte in; char_ready_o accept strobe
//   vram_addr_o/we_o/data_o  VRAM port B address {row[4:0], col[6:0]}, write enable, write data
//   vram_data_i              VRAM port B read data
//   cursor_col_o/row_o       cursor position
//   busy_o                   clear or scroll in progress
//
// Read timing assumed on port B: vram_data_i shows the cell addressed by the read issued in SCR_RD
// during the following SCR_WR cycle, so each copied cell costs exactly one read and one write cycle.

module vram_text_writer #(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 30,
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [7:0]  char_i,
  input  logic        char_valid_i,
  output logic        char_ready_o,
  output logic [11:0] vram_addr_o,
  output logic        vram_we_o,
  output logic [7:0]  vram_data_o,
  input  logic [7:0]  vram_data_i,
  output logic [6:0]  cursor_col_o,
  output logic [4:0]  cursor_row_o,
  output logic        busy_o
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
`ifdef VRAM_WRITER_SCROLL_EN
  localparam logic [4:0] LAST_DST = 5'(ROWS - 2);
`endif

  typedef enum logic [2:0] {
    CLEAR_ALL,
    IDLE,
`ifdef VRAM_WRITER_SCROLL_EN
    SCR_RD,
    SCR_WR,
`endif
    CLEAR_ROW
  } state_t;

  state_t      r_state;
  logic        r_ready;
  logic        r_we;
  logic [11:0] r_addr;
  logic [7:0]  r_data;
  logic [6:0]  r_col;
  logic [4:0]  r_row;
  logic [6:0]  r_scol;   // sweep column for clear/scroll
  logic [4:0]  r_srow;   // sweep row (destination row while scrolling)

  logic w_take;
  logic w_print;
  logic w_adv;

`ifndef VRAM_WRITER_SCROLL_EN
  logic w_unused_rd;
  assign w_unused_rd = ^vram_data_i;
`endif

  // r_ready is only ever set in IDLE, so it doubles as the state qualifier.
  assign w_take  = char_valid_i && r_ready;
  assign w_print = (char_i >= 8'h20) && (char_i <= 8'h7E);
  // Row advance happens on LF or on a printable written into the last column.
  assign w_adv   = w_take && ((char_i == 8'h0A) || (w_print && (r_col == LAST_COL)));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= CLEAR_ALL;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_scol  <= '0;
      r_srow  <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        CLEAR_ALL: begin
          r_we   <= 1'b1;
          r_addr <= {r_srow, r_scol};
          r_data <= BLANK_CHAR;
          if (r_scol == LAST_COL) begin
            r_scol <= '0;
            if (r_srow == LAST_ROW) begin
              r_srow  <= '0;
              r_col   <= '0;
              r_row   <= '0;
              r_ready <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_srow <= r_srow + 5'd1;
            end
          end else begin
            r_scol <= r_scol + 7'd1;
          end
        end

        IDLE: begin
          if (w_take) begin
            if (w_print) begin
              r_we   <= 1'b1;
              r_addr <= {r_row, r_col};
              r_data <= char_i;
              r_col  <= (r_col == LAST_COL) ? 7'd0 : r_col + 7'd1;
            end else if (char_i == 8'h0D || char_i == 8'h0A) begin
              r_col <= '0;
            end else if (char_i == 8'h08) begin
              if (r_col != 7'd0) begin
                r_col  <= r_col - 7'd1;
                r_we   <= 1'b1;
                r_addr <= {r_row, r_col - 7'd1};
                r_data <= BLANK_CHAR;
              end
            end else if (char_i == 8'h0C) begin
              r_ready <= 1'b0;
              r_scol  <= '0;
              r_srow  <= '0;
              r_state <= CLEAR_ALL;
            end
          end
          if (w_adv) begin
            if (r_row != LAST_ROW) begin
              r_row <= r_row + 5'd1;
            end else begin
              r_ready <= 1'b0;
              r_scol  <= '0;
              r_srow  <= '0;
`ifdef VRAM_WRITER_SCROLL_EN
              r_state <= SCR_RD;
`else
              r_row   <= '0;
              r_state <= CLEAR_ROW;
`endif
            end
          end
        end

`ifdef VRAM_WRITER_SCROLL_EN
        SCR_RD: begin
          r_addr  <= {r_srow + 5'd1, r_scol};
          r_state <= SCR_WR;
        end

        SCR_WR: begin
          r_we    <= 1'b1;
          r_addr  <= {r_srow, r_scol};
          r_data  <= vram_data_i;
          r_state <= SCR_RD;
          if (r_scol == LAST_COL) begin
            r_scol <= '0;
            if (r_srow == LAST_DST) begin
              r_srow  <= LAST_ROW;
              r_state <= CLEAR_ROW;
            end else begin
              r_srow <= r_srow + 5'd1;
            end
          end else begin
            r_scol <= r_scol + 7'd1;
          end
        end
`endif

        CLEAR_ROW: begin
          r_we   <= 1'b1;
          r_addr <= {r_srow, r_scol};
          r_data <= BLANK_CHAR;
          if (r_scol == LAST_COL) begin
            r_scol  <= '0;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_scol <= r_scol + 7'd1;
          end
        end

        default: r_state <= CLEAR_ALL;
      endcase
    end
  end

  assign char_ready_o = r_ready;
  assign vram_addr_o  = r_addr;
  assign vram_we_o    = r_we;
  assign vram_data_o  = r_data;
  assign cursor_col_o = r_col;
  assign cursor_row_o = r_row;
  assign busy_o       = (r_state != IDLE);

endmodule

// File: tb/tb_vram_text_writer.sv
// Bench for vram_text_writer: VRAM model on port B, screen/cursor reference model, directed and random byte streams.
// Latency: not applicable (bench).
// Backpressure: bytes are only offered after char_ready_o is seen high; every wait has a cycle bound.

module tb_vram_text_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  char_in = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [11:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdat;
  logic [7:0]  vram_rd;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;
  logic        busy;

  always #5 clk = ~clk;

  vram_text_writer dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .char_i       (char_in),
    .char_valid_i (char_valid),
    .char_ready_o (char_ready),
    .vram_addr_o  (vram_addr),
    .vram_we_o    (vram_we),
    .vram_data_o  (vram_wdat),
    .vram_data_i  (vram_rd),
    .cursor_col_o (cur_col),
    .cursor_row_o (cur_row),
    .busy_o       (busy)
  );

  // VRAM port B model: reads follow the registered address, writes commit on the clock edge.
  logic [7:0] mem [0:4095];
  assign vram_rd = mem[vram_addr];

  int         checks = 0;
  int         failures = 0;
  int         wr_count = 0;
  int         wr_nonblank = 0;
  int         wr_oob = 0;
  logic [1:0] fill_req = 2'd1;   // 1: fill with 8'hFF, 2: row r gets r+8'h40

  always @(posedge clk) begin
    if (fill_req == 2'd1) begin
      for (int a = 0; a < 4096; a++) mem[a] <= 8'hFF;
    end else if (fill_req == 2'd2) begin
      for (int r = 0; r < 30; r++)
        for (int c = 0; c < 80; c++)
          mem[{5'(r), 7'(c)}] <= 8'(r + 64);
    end else if (vram_we === 1'b1) begin
      mem[vram_addr] <= vram_wdat;
      wr_count++;
      if (vram_wdat != 8'h20) wr_nonblank++;
      if (vram_addr[6:0] >= 7'd80 || vram_addr[11:7] >= 5'd30) wr_oob++;
    end
  end

  // Reference model: screen contents and cursor, driven by the console rules.
  logic [7:0] exp_scr [0:29][0:79];
  int         exp_r = 0;
  int         exp_c = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic m_blank_row(input int r);
    for (int c = 0; c < 80; c++) exp_scr[r][c] = 8'h20;
  endtask

  task automatic m_clear();
    for (int r = 0; r < 30; r++) m_blank_row(r);
    exp_r = 0;
    exp_c = 0;
  endtask

  task automatic m_pattern();
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 80; c++)
        exp_scr[r][c] = 8'(r + 64);
  endtask

  task automatic m_advance();
    if (exp_r < 29) begin
      exp_r++;
    end else begin
`ifdef VRAM_WRITER_SCROLL_EN
      for (int r = 0; r < 29; r++)
        for (int c = 0; c < 80; c++)
          exp_scr[r][c] = exp_scr[r + 1][c];
      m_blank_row(29);
`else
      exp_r = 0;
      m_blank_row(0);
`endif
    end
  endtask

  task automatic m_apply(input logic [7:0] ch);
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      exp_scr[exp_r][exp_c] = ch;
      if (exp_c == 79) begin
        exp_c = 0;
        m_advance();
      end else begin
        exp_c++;
      end
    end else if (ch == 8'h0D) begin
      exp_c = 0;
    end else if (ch == 8'h0A) begin
      exp_c = 0;
      m_advance();
    end else if (ch == 8'h08) begin
      if (exp_c > 0) begin
        exp_c--;
        exp_scr[exp_r][exp_c] = 8'h20;
      end
    end else if (ch == 8'h0C) begin
      m_clear();
    end
  endtask

  // All tasks below are entered and left 1 time unit after a rising edge.
  task automatic wait_ready(input int bound, output int n);
    n = 0;
    while (char_ready !== 1'b1 && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic send(input logic [7:0] ch);
    int n;
    wait_ready(6000, n);
    if (char_ready !== 1'b1) chk("send_ready_timeout", {31'd0, char_ready}, 32'd1);
    char_in    = ch;
    char_valid = 1'b1;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    m_apply(ch);
  endtask

  task automatic settle();
    int n;
    wait_ready(6000, n);
    if (char_ready !== 1'b1) chk("settle_timeout", {31'd0, char_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_screen(input string tag);
    int bad;
    bad = 0;
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 80; c++)
        if (mem[{5'(r), 7'(c)}] !== exp_scr[r][c]) bad++;
    chk(tag, 32'(bad), 32'd0);
    chk({tag, "_col"}, {25'd0, cur_col}, 32'(exp_c));
    chk({tag, "_row"}, {27'd0, cur_row}, 32'(exp_r));
  endtask

  task automatic load_pattern();
    fill_req = 2'd2;
    @(posedge clk);
    #1;
    fill_req = 2'd0;
    m_pattern();
  endtask

  initial begin
    int n;
    int base_wr;
    int base_nb;
    int base_oob;
    int k;
    logic [7:0] ch;

    // Reset: one clock with reset high; first edge also pre-fills VRAM with 8'hFF.
    @(posedge clk);
    #1;
    fill_req = 2'd0;
    chk("rst_ready", {31'd0, char_ready}, 32'd0);
    chk("rst_we",    {31'd0, vram_we},    32'd0);
    chk("rst_addr",  {20'd0, vram_addr},  32'd0);
    chk("rst_data",  {24'd0, vram_wdat},  32'd0);
    chk("rst_col",   {25'd0, cur_col},    32'd0);
    chk("rst_row",   {27'd0, cur_row},    32'd0);
    chk("rst_busy",  {31'd0, busy},       32'd1);
    reset    = 1'b0;
    base_wr  = wr_count;
    base_nb  = wr_nonblank;
    base_oob = wr_oob;
    m_clear();
    wait_ready(3000, n);
    chk("clear_cycles", 32'(n), 32'd2400);
    @(posedge clk);
    #1;
    chk("clear_writes",   32'(wr_count - base_wr),    32'd2400);
    chk("clear_nonblank", 32'(wr_nonblank - base_nb), 32'd0);
    chk("clear_oob",      32'(wr_oob - base_oob),     32'd0);
    chk("clear_busy",     {31'd0, busy},              32'd0);
    cmp_screen("clear_screen");

    // 'A' at home.
    send(8'h41);
    chk("A_we",   {31'd0, vram_we},   32'd1);
    chk("A_addr", {20'd0, vram_addr}, 32'h000);
    chk("A_data", {24'd0, vram_wdat}, 32'h41);
    chk("A_col",  {25'd0, cur_col},   32'd1);
    chk("A_row",  {27'd0, cur_row},   32'd0);

    // Form feed, then a full row of 'B' back-to-back, then 'C' on the next row.
    send(8'h0C);
    for (int i = 0; i < 80; i++) send(8'h42);
    chk("B_addr", {20'd0, vram_addr}, 32'h04F);
    chk("B_data", {24'd0, vram_wdat}, 32'h42);
    chk("B_col",  {25'd0, cur_col},   32'd0);
    chk("B_row",  {27'd0, cur_row},   32'd1);
    send(8'h43);
    chk("C_we",   {31'd0, vram_we},   32'd1);
    chk("C_addr", {20'd0, vram_addr}, 32'h080);
    chk("C_data", {24'd0, vram_wdat}, 32'h43);

    // Backspace and carriage return on row 3.
    send(8'h0A);
    send(8'h0A);
    send(8'h58);
    send(8'h59);
    send(8'h08);
    chk("BS_we",   {31'd0, vram_we},   32'd1);
    chk("BS_addr", {20'd0, vram_addr}, 32'h181);
    chk("BS_data", {24'd0, vram_wdat}, 32'h20);
    send(8'h0D);
    chk("CR_col", {25'd0, cur_col}, 32'd0);
    chk("CR_row", {27'd0, cur_row}, 32'd3);
    send(8'h08);
    chk("BS0_we",  {31'd0, vram_we}, 32'd0);
    chk("BS0_col", {25'd0, cur_col}, 32'd0);
    chk("BS0_row", {27'd0, cur_row}, 32'd3);
    settle();
    cmp_screen("directed_screen");

    // Random byte stream with idle gaps, cursor tracked after every byte.
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      k = $urandom_range(0, 99);
      if (k < 80)      ch = 8'($urandom_range(32, 126));
      else if (k < 85) ch = 8'h0D;
      else if (k < 90) ch = 8'h0A;
      else if (k < 95) ch = 8'h08;
      else begin
        case ($urandom_range(0, 3))
          0:       ch = 8'h00;
          1:       ch = 8'h7F;
          2:       ch = 8'h1B;
          default: ch = 8'hFF;
        endcase
      end
      send(ch);
      chk("rand_col", {25'd0, cur_col}, 32'(exp_c));
      chk("rand_row", {27'd0, cur_row}, 32'(exp_r));
    end
    settle();
    cmp_screen("rand_screen");

    // Line feed on the last row of a patterned screen.
    send(8'h0C);
    settle();
    load_pattern();
    repeat (29) send(8'h0A);
    chk("pre_scroll_row", {27'd0, cur_row}, 32'd29);
    send(8'h0A);
    chk("scroll_ready_drop", {31'd0, char_ready}, 32'd0);
    wait_ready(6000, n);
`ifdef VRAM_WRITER_SCROLL_EN
    chk("scroll_ready_low", 32'(n), 32'd4720);
`else
    chk("scroll_ready_low", 32'(n), 32'd80);
`endif
    @(posedge clk);
    #1;
    cmp_screen("scroll_screen");

    // Reset 100 cycles into the same operation.
    send(8'h0C);
    settle();
    load_pattern();
    repeat (29) send(8'h0A);
    send(8'h0A);
    repeat (99) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_we",    {31'd0, vram_we},    32'd0);
    chk("abort_busy",  {31'd0, busy},       32'd1);
    chk("abort_ready", {31'd0, char_ready}, 32'd0);
    base_wr = wr_count;
    base_nb = wr_nonblank;
    m_clear();
    wait_ready(3000, n);
    chk("abort_clear_cycles", 32'(n), 32'd2400);
    @(posedge clk);
    #1;
    chk("abort_writes",   32'(wr_count - base_wr),    32'd2400);
    chk("abort_nonblank", 32'(wr_nonblank - base_nb), 32'd0);
    cmp_screen("abort_screen");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
